// File: rtl/mux21_arbiter_if.sv
// Request/grant bundle between two mux21 requesters and the arbiter that owns SEL.
// The master modport is the requester side; the slave modport is the arbiter.
interface mux21_arbiter_if;
    logic REQ_A;
    logic REQ_B;
    logic GNT_A;
    logic GNT_B;
    logic SEL;
    logic BUSY;

    modport master (
        output REQ_A, REQ_B,
        input  GNT_A, GNT_B, SEL, BUSY
    );

    modport slave (
        input  REQ_A, REQ_B,
        output GNT_A, GNT_B, SEL, BUSY
    );
endinterface

// File: rtl/mux21_arbiter.sv
// Two-requester round-robin arbiter driving the SEL line of a shared 2:1 mux.
// A grant is capped at MAX_HOLD cycles only while the other side is waiting.
module mux21_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    mux21_arbiter_if.slave arb
);

    localparam int                CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic             last, last_nxt;
    logic             sel, sel_nxt;
    logic             gnt_a, gnt_b, busy;

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        last_nxt     = last;
        sel_nxt      = sel;

        case (state)
            IDLE: begin
                // On a tie, A wins unless A was the last side served.
                if (arb.REQ_A && (!arb.REQ_B || last))
                    state_nxt = GRANT_A;
                else if (arb.REQ_B)
                    state_nxt = GRANT_B;
            end
            GRANT_A: begin
                if (!arb.REQ_A)
                    state_nxt = arb.REQ_B ? GRANT_B : IDLE;
                else if (hold_cnt == HOLD_LAST) begin
                    if (arb.REQ_B)
                        state_nxt = GRANT_B;
                    else
                        hold_cnt_nxt = '0;
                end else
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
            GRANT_B: begin
                if (!arb.REQ_B)
                    state_nxt = arb.REQ_A ? GRANT_A : IDLE;
                else if (hold_cnt == HOLD_LAST) begin
                    if (arb.REQ_A)
                        state_nxt = GRANT_A;
                    else
                        hold_cnt_nxt = '0;
                end else
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase

        // SEL and last move only when a new grant begins; IDLE keeps the old SEL.
        if (state_nxt != state) begin
            if (state_nxt == GRANT_A) begin
                hold_cnt_nxt = '0;
                last_nxt     = 1'b0;
                sel_nxt      = 1'b0;
            end else if (state_nxt == GRANT_B) begin
                hold_cnt_nxt = '0;
                last_nxt     = 1'b1;
                sel_nxt      = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;
            sel      <= 1'b0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            last     <= last_nxt;
            sel      <= sel_nxt;
            gnt_a    <= (state_nxt == GRANT_A);
            gnt_b    <= (state_nxt == GRANT_B);
            busy     <= (state_nxt != IDLE);
        end
    end

    assign arb.GNT_A = gnt_a;
    assign arb.GNT_B = gnt_b;
    assign arb.SEL   = sel;
    assign arb.BUSY  = busy;

endmodule

// File: tb/tb_mux21_arbiter.sv
// Randomised and directed bench for mux21_arbiter against a cycle-level ownership model,
// including a behavioural mux21 fed A=0, B=1 from the arbiter's SEL.
module tb_mux21_arbiter;

    localparam int MAX_HOLD = 4;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    mux21_arbiter_if bus ();

    mux21_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .arb  (bus.slave)
    );

    // Shared mux with constant sources so Z reveals which side is steered.
    logic mux_a, mux_b, mux_z;
    assign mux_a = 1'b0;
    assign mux_b = 1'b1;
    assign mux_z = bus.SEL ? mux_b : mux_a;

    // Model: owner 0=none, 1=A, 2=B; run = cycles the current owner has held so far.
    int   m_owner;
    int   m_run;
    logic m_last;
    logic m_sel;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_run   = 0;
        m_last  = 1'b1;
        m_sel   = 1'b0;
    endtask

    task automatic model_edge(input logic a, input logic b);
        int   nxt;
        logic mine, other;
        nxt = m_owner;
        if (m_owner == 0) begin
            if (a && b)  nxt = m_last ? 1 : 2;
            else if (a)  nxt = 1;
            else if (b)  nxt = 2;
        end else begin
            mine  = (m_owner == 1) ? a : b;
            other = (m_owner == 1) ? b : a;
            if (!mine)
                nxt = other ? 3 - m_owner : 0;
            else if (other && (m_run % MAX_HOLD) == 0)
                nxt = 3 - m_owner;
        end
        if (nxt != 0 && nxt != m_owner) begin
            m_run  = 1;
            m_last = (nxt == 2);
            m_sel  = (nxt == 2);
        end else if (nxt != 0)
            m_run++;
        m_owner = nxt;
    endtask

    task automatic compare_all();
        check_eq("gnt_a", bus.GNT_A, m_owner == 1);
        check_eq("gnt_b", bus.GNT_B, m_owner == 2);
        check_eq("sel",   bus.SEL,   m_sel);
        check_eq("busy",  bus.BUSY,  m_owner != 0);
        check_eq("mux_z", mux_z,     m_sel);
        check_eq("gnt_exclusive", bus.GNT_A & bus.GNT_B, 0);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge(bus.REQ_A, bus.REQ_B);
        #1;
        compare_all();
    endtask

    task automatic step(input logic a, input logic b);
        @(negedge CLK);
        bus.REQ_A = a;
        bus.REQ_B = b;
        tick();
    endtask

    initial begin
        int   cnt_a, cnt_b;
        logic ra, rb;

        bus.REQ_A = 1'b0;
        bus.REQ_B = 1'b0;
        RST_N     = 1'b0;
        model_reset();
        #12;
        compare_all();
        RST_N = 1'b1;

        // Enter GRANT_B, then reset asynchronously between edges.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        model_reset();
        check_eq("rst_async_gnt_b", bus.GNT_B, 0);
        check_eq("rst_async_sel",   bus.SEL,   0);
        check_eq("rst_async_busy",  bus.BUSY,  0);
        bus.REQ_A = 1'b1;
        bus.REQ_B = 1'b1;
        #1;
        RST_N = 1'b1;
        tick();
        check_eq("tie_after_reset_gnt_a", bus.GNT_A, 1);

        // Continuous contention: 20 granted cycles split 12 A / 8 B.
        cnt_a = int'(bus.GNT_A);
        cnt_b = int'(bus.GNT_B);
        for (int i = 0; i < 19; i++) begin
            step(1'b1, 1'b1);
            cnt_a += int'(bus.GNT_A);
            cnt_b += int'(bus.GNT_B);
        end
        check_eq("contend_cnt_a", cnt_a, 12);
        check_eq("contend_cnt_b", cnt_b, 8);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Single requester A for 3 cycles, then idle.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("idle_busy", bus.BUSY, 0);
        step(1'b0, 1'b0);

        // Uncontended B holds through counter wrap.
        cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            cnt_b += int'(bus.GNT_B & bus.SEL);
        end
        check_eq("uncontended_b_cycles", cnt_b, 10);
        step(1'b0, 1'b0);
        check_eq("idle_keeps_sel_b", bus.SEL, 1);

        // Early release of A with B pending: direct handover.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check_eq("early_release_gnt_b", bus.GNT_B, 1);
        check_eq("early_release_gnt_a", bus.GNT_A, 0);
        step(1'b0, 1'b0);

        // Random request traffic with sticky requests.
        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) ra = ~ra;
            if ($urandom_range(3) == 0) rb = ~rb;
            step(ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
